// File: rtl/acquisition_sweep_controller.sv
// Purpose : sequences swept-source A-line capture into a ping-pong sample RAM and flags completed frames.
// Latency : wr_en/wr_addr follow the accepted sample_valid by 1 cycle; all outputs are registered.
// Backpress: none on samples; a frame finished before the previous one is acknowledged raises sticky overflow.
// Optional watchdog: define SWEEP_WATCHDOG_EN to abort A-lines that stall for WDOG_CYCLES cycles without samples.
module acquisition_sweep_controller #(
   parameter int NSAMPLES    = 1170,
   parameter int NALINES     = 512,
   parameter int WDOG_CYCLES = 4096
) (
   input  logic        clock,
   input  logic        aclr,
   input  logic        enable,
   input  logic        trigger,
   input  logic        sample_valid,
   input  logic        frame_ack,
   output logic [10:0] wr_addr,
   output logic        wr_en,
   output logic        bank,
   output logic [9:0]  aline_count,
   output logic        frame_ready,
   output logic        busy,
   output logic        overflow,
   output logic        timeout
);

   typedef enum logic [2:0] {
      IDLE,
      WAIT_TRIG,
      CAPTURE,
      ALINE_DONE,
      FRAME_DONE
   } state_t;

   localparam logic [10:0] LAST_S = 11'(NSAMPLES - 1);
   localparam logic [9:0]  LAST_A = 10'(NALINES - 1);

   state_t      state, state_nx;
   logic        trig_d;
   logic [10:0] sidx;
   logic        trig_edge;
   logic        last_sample;
   logic        last_aline;
   logic        wdog_hit;

   assign trig_edge   = trigger & ~trig_d;
   assign last_sample = (sidx == LAST_S);
   assign last_aline  = (aline_count == LAST_A);

   // State register.
   always_ff @(posedge clock or posedge aclr) begin
      if (aclr) state <= IDLE;
      else      state <= state_nx;
   end

   // Next-state decode; disarming in WAIT_TRIG takes priority over a coincident trigger edge.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:       if (enable) state_nx = WAIT_TRIG;
         WAIT_TRIG: begin
            if (!enable)        state_nx = IDLE;
            else if (trig_edge) state_nx = CAPTURE;
         end
         CAPTURE: begin
            if (sample_valid && last_sample) state_nx = ALINE_DONE;
            else if (wdog_hit)               state_nx = WAIT_TRIG;
         end
         ALINE_DONE: begin
            if (last_aline)  state_nx = FRAME_DONE;
            else if (enable) state_nx = WAIT_TRIG;
            else             state_nx = IDLE;
         end
         FRAME_DONE: state_nx = enable ? WAIT_TRIG : IDLE;
         default:    state_nx = IDLE;
      endcase
   end

   // Trigger history for edge detection, sample index, and the registered RAM write port.
   always_ff @(posedge clock or posedge aclr) begin
      if (aclr) begin
         trig_d  <= 1'b0;
         sidx    <= '0;
         wr_en   <= 1'b0;
         wr_addr <= '0;
      end else begin
         trig_d <= trigger;
         wr_en  <= (state == CAPTURE) && sample_valid;
         if (state == WAIT_TRIG && state_nx == CAPTURE) begin
            sidx <= '0;
         end else if (state == CAPTURE && sample_valid) begin
            sidx    <= sidx + 11'd1;
            wr_addr <= sidx;
         end
      end
   end

   // A-line counter and bank; a disarm between A-lines discards the partial frame but keeps the bank.
   always_ff @(posedge clock or posedge aclr) begin
      if (aclr) begin
         aline_count <= '0;
         bank        <= 1'b0;
      end else begin
         case (state)
            WAIT_TRIG:  if (!enable) aline_count <= '0;
            ALINE_DONE: begin
               if (!last_aline) aline_count <= enable ? aline_count + 10'd1 : 10'd0;
            end
            FRAME_DONE: begin
               aline_count <= '0;
               bank        <= ~bank;
            end
            default: ;
         endcase
      end
   end

   // Frame handshake: a new frame wins over a coincident ack; an unacked frame being replaced is an overflow.
   always_ff @(posedge clock or posedge aclr) begin
      if (aclr) begin
         frame_ready <= 1'b0;
         overflow    <= 1'b0;
      end else if (state == FRAME_DONE) begin
         frame_ready <= 1'b1;
         if (frame_ready && !frame_ack) overflow <= 1'b1;
      end else if (frame_ready && frame_ack) begin
         frame_ready <= 1'b0;
      end
   end

   // Busy mirrors the registered state leaving IDLE.
   always_ff @(posedge clock or posedge aclr) begin
      if (aclr) busy <= 1'b0;
      else      busy <= (state_nx != IDLE);
   end

`ifdef SWEEP_WATCHDOG_EN
   localparam int WW = $clog2(WDOG_CYCLES + 1);

   logic [WW-1:0] wdog_cnt;

   assign wdog_hit = (state == CAPTURE) && !sample_valid && (wdog_cnt == WW'(WDOG_CYCLES - 1));

   // Counts consecutive sample-free CAPTURE cycles; zero on CAPTURE entry since it rests at 0 elsewhere.
   always_ff @(posedge clock or posedge aclr) begin
      if (aclr)                                wdog_cnt <= '0;
      else if (state != CAPTURE || sample_valid) wdog_cnt <= '0;
      else                                     wdog_cnt <= wdog_cnt + 1'b1;
   end

   // Sticky record that an A-line was abandoned and will be recaptured.
   always_ff @(posedge clock or posedge aclr) begin
      if (aclr)          timeout <= 1'b0;
      else if (wdog_hit) timeout <= 1'b1;
   end
`else
   assign wdog_hit = 1'b0;
   assign timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_acquisition_sweep_controller.sv
// Bench for acquisition_sweep_controller: NSAMPLES=8, NALINES=2, WDOG_CYCLES=16.
// Expected write addresses are queued as samples are driven and popped as wr_en appears.
// Covers reset, frames, trigger edge rules, overflow/ack, disarm, mid-capture reset and the optional watchdog.
module tb_acquisition_sweep_controller;

   logic        clock = 1'b0;
   logic        aclr;
   logic        enable;
   logic        trigger;
   logic        sample_valid;
   logic        frame_ack;
   logic [10:0] wr_addr;
   logic        wr_en;
   logic        bank;
   logic [9:0]  aline_count;
   logic        frame_ready;
   logic        busy;
   logic        overflow;
   logic        timeout;

   int checks = 0;
   int errors = 0;
   int wr_cnt = 0;
   int exp_writes = 0;
   int wr_before;
   int unsigned exp_q[$];

   acquisition_sweep_controller #(
      .NSAMPLES   (8),
      .NALINES    (2),
      .WDOG_CYCLES(16)
   ) dut (
      .clock       (clock),
      .aclr        (aclr),
      .enable      (enable),
      .trigger     (trigger),
      .sample_valid(sample_valid),
      .frame_ack   (frame_ack),
      .wr_addr     (wr_addr),
      .wr_en       (wr_en),
      .bank        (bank),
      .aline_count (aline_count),
      .frame_ready (frame_ready),
      .busy        (busy),
      .overflow    (overflow),
      .timeout     (timeout)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic push_sample(input int unsigned idx);
      sample_valid = 1'b1;
      exp_q.push_back(idx);
      exp_writes++;
      tick();
      sample_valid = 1'b0;
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_wr_en"},  32'(wr_en), 0);
      check({tag, "_wr_addr"}, 32'(wr_addr), 0);
      check({tag, "_bank"},   32'(bank), 0);
      check({tag, "_aline"},  32'(aline_count), 0);
      check({tag, "_ready"},  32'(frame_ready), 0);
      check({tag, "_busy"},   32'(busy), 0);
      check({tag, "_ovf"},    32'(overflow), 0);
      check({tag, "_tmo"},    32'(timeout), 0);
   endtask

   // One full A-line from WAIT_TRIG; ack_fd raises frame_ack exactly in the FRAME_DONE cycle.
   task automatic do_aline(input bit ack_fd);
      trigger = 1'b1;
      tick();
      trigger = 1'b0;
      for (int i = 0; i < 8; i++) push_sample(i);
      tick();
      if (ack_fd) frame_ack = 1'b1;
      tick();
      frame_ack = 1'b0;
      tick();
   endtask

   // Scoreboard: every write must match the next queued address.
   always @(negedge clock) begin
      if (wr_en === 1'b1) begin
         wr_cnt++;
         if (exp_q.size() == 0) check("wr_en_unexpected", 32'(wr_en), 0);
         else                   check("wr_addr", 32'(wr_addr), exp_q.pop_front());
      end
   end

   initial begin
      aclr = 1'b1; enable = 1'b0; trigger = 1'b0; sample_valid = 1'b0; frame_ack = 1'b0;
      #3;
      check_reset("rst");
      tick(); tick();
      aclr = 1'b0;

      // Arm, then one frame of two A-lines.
      enable = 1'b1;
      tick();
      check("busy_armed", 32'(busy), 1);
      do_aline(1'b0);
      check("aline1", 32'(aline_count), 1);
      check("bank_mid", 32'(bank), 0);
      check("ready_mid", 32'(frame_ready), 0);
      do_aline(1'b0);
      check("wr_cnt_f1", 32'(wr_cnt), 16);
      check("ready_f1", 32'(frame_ready), 1);
      check("bank_f1", 32'(bank), 1);
      check("aline_f1", 32'(aline_count), 0);
      check("ovf_f1", 32'(overflow), 0);

      // Held trigger starts one capture; a second pulse mid-capture is ignored.
      trigger = 1'b1;
      repeat (20) tick();
      trigger = 1'b0;
      for (int i = 0; i < 4; i++) push_sample(i);
      trigger = 1'b1;
      push_sample(4);
      trigger = 1'b0;
      for (int i = 5; i < 8; i++) push_sample(i);
      tick(); tick(); tick();
      check("aline_held", 32'(aline_count), 1);
      check("wr_cnt_held", 32'(wr_cnt), 24);

      // Second frame with no ack -> overflow.
      do_aline(1'b0);
      check("ovf_f2", 32'(overflow), 1);
      check("bank_f2", 32'(bank), 0);
      check("ready_f2", 32'(frame_ready), 1);

      // Ack clears ready; overflow stays; stray ack is harmless.
      frame_ack = 1'b1; tick(); frame_ack = 1'b0;
      check("ready_acked", 32'(frame_ready), 0);
      check("ovf_sticky", 32'(overflow), 1);
      frame_ack = 1'b1; tick(); frame_ack = 1'b0;
      check("ready_stray_ack", 32'(frame_ready), 0);

      // Disarm between A-lines discards the partial frame.
      do_aline(1'b0);
      check("aline_pre_disarm", 32'(aline_count), 1);
      enable = 1'b0;
      tick();
      check("aline_disarm", 32'(aline_count), 0);
      check("busy_disarm", 32'(busy), 0);
      check("bank_disarm", 32'(bank), 0);
      tick();
      check("busy_idle", 32'(busy), 0);

      // Reset in the middle of an A-line, then samples with no trigger.
      enable = 1'b1;
      tick();
      trigger = 1'b1; tick(); trigger = 1'b0;
      for (int i = 0; i < 3; i++) push_sample(i);
      tick();
      aclr = 1'b1;
      #1;
      check_reset("midrst");
      tick();
      aclr = 1'b0;
      wr_before = wr_cnt;
      sample_valid = 1'b1;
      repeat (5) tick();
      sample_valid = 1'b0;
      tick();
      check("no_wr_without_trig", 32'(wr_cnt), 32'(wr_before));

      // Fresh run: second FRAME_DONE coincides with frame_ack.
      aclr = 1'b1; tick(); aclr = 1'b0;
      tick();
      do_aline(1'b0);
      do_aline(1'b0);
      do_aline(1'b0);
      do_aline(1'b1);
      check("ovf_ack_same", 32'(overflow), 0);
      check("ready_ack_same", 32'(frame_ready), 1);
      check("bank_ack_same", 32'(bank), 0);

`ifdef SWEEP_WATCHDOG_EN
      // Stalled A-line: 3 samples then silence until the watchdog fires.
      trigger = 1'b1; tick(); trigger = 1'b0;
      for (int i = 0; i < 3; i++) push_sample(i);
      repeat (15) tick();
      check("tmo_early", 32'(timeout), 0);
      tick();
      check("tmo_fired", 32'(timeout), 1);
      check("tmo_aline", 32'(aline_count), 0);
      check("tmo_busy", 32'(busy), 1);
      do_aline(1'b0);
      check("tmo_recap_aline", 32'(aline_count), 1);
      check("tmo_sticky", 32'(timeout), 1);
`else
      check("tmo_off", 32'(timeout), 0);
`endif

      tick();
      check("queue_empty", 32'(exp_q.size()), 0);
      check("wr_total", 32'(wr_cnt), 32'(exp_writes));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/acquisition_sweep_controller.md
ACQUISITION_SWEEP_CONTROLLER -- requirements
Module: acquisition_sweep_controller

Interface
REQ-001 Parameter NSAMPLES, default 1170: samples per A-line, range 2..2048.
REQ-002 Parameter NALINES, default 512: A-lines per frame, range 1..1024.
REQ-003 Parameter WDOG_CYCLES, default 4096: idle-sample timeout in clock cycles.
REQ-004 clock  in  1  sole clock, all state on rising edge.
REQ-005 aclr  in  1  reset, asynchronous, active-high.
REQ-006 enable  in  1  arm acquisition, level.
REQ-007 trigger  in  1  sweep start, pre-synchronized; rising edge detected internally.
REQ-008 sample_valid  in  1  ADC sample strobe, one sample per high cycle.
REQ-009 frame_ack  in  1  consumer acknowledges frame_ready.
REQ-010 wr_addr  out  11  sample RAM write address.
REQ-011 wr_en  out  1  sample RAM write strobe.
REQ-012 bank  out  1  RAM bank currently written.
REQ-013 aline_count  out  10  index of A-line being captured.
REQ-014 frame_ready  out  1  completed frame available in bank ~bank.
REQ-015 busy  out  1  high in any state except IDLE.
REQ-016 overflow  out  1  sticky: frame completed while previous frame unacknowledged.
REQ-017 timeout  out  1  sticky: A-line aborted by watchdog.

Function
REQ-018 All outputs registered; states IDLE, WAIT_TRIG, CAPTURE, ALINE_DONE, FRAME_DONE.
REQ-019 IDLE: enable=1 -> WAIT_TRIG next cycle; else remain.
REQ-020 WAIT_TRIG: enable=0 -> IDLE, aline_count cleared, bank unchanged, partial frame discarded.
REQ-021 WAIT_TRIG: trigger rising edge (trigger=1, previous-cycle trigger=0) -> CAPTURE, sample index cleared to 0.
REQ-022 CAPTURE: each sample_valid cycle -> wr_en=1 and wr_addr=sample index on the next cycle (latency 1), index increments.
REQ-023 CAPTURE: sample_valid with index = NSAMPLES-1 -> last write issued, ALINE_DONE next; no write ever has wr_addr >= NSAMPLES.
REQ-024 CAPTURE: trigger edges ignored; enable=0 does not abort, A-line completes normally.
REQ-025 ALINE_DONE (1 cycle): aline_count = NALINES-1 -> FRAME_DONE; else aline_count+1, -> WAIT_TRIG if enable=1, IDLE otherwise (aline_count cleared).
REQ-026 FRAME_DONE (1 cycle): bank toggles, aline_count cleared, frame_ready set, -> WAIT_TRIG if enable=1 else IDLE.
REQ-027 frame_ready clears on the cycle after frame_ack=1; frame_ack with frame_ready=0 ignored.
REQ-028 FRAME_DONE with frame_ready already 1 and frame_ack=0 -> overflow set; frame_ready stays 1.
REQ-029 FRAME_DONE coincident with frame_ack=1 -> frame_ready stays 1, no overflow.
REQ-030 wr_en=0 in every cycle not following a CAPTURE sample_valid.
REQ-031 busy=0 only in IDLE.

Reset
REQ-032 aclr=1 forces immediately: state IDLE, wr_addr=0, wr_en=0, bank=0, aline_count=0, frame_ready=0, busy=0, overflow=0, timeout=0, trigger history=0.
REQ-033 aclr mid-CAPTURE abandons the A-line; no further wr_en until a new trigger edge after reset release.
REQ-034 overflow and timeout clear only by aclr.

Configuration
REQ-035 Macro SWEEP_WATCHDOG_EN defined: counter clears on entering CAPTURE and on each sample_valid; reaching WDOG_CYCLES consecutive cycles without sample_valid in CAPTURE -> WAIT_TRIG, aline_count unchanged, A-line recaptured on next trigger, timeout set.
REQ-036 SWEEP_WATCHDOG_EN undefined: no watchdog logic, CAPTURE waits indefinitely, timeout constant 0.

Verification
REQ-037 NSAMPLES=8, NALINES=2, enable=1, two triggers each followed by 8 sample_valid -> wr_addr 0..7 twice, wr_en exactly 16 cycles, frame_ready=1, bank=1.
REQ-038 Trigger held high 20 cycles in WAIT_TRIG -> single capture start; second trigger pulse during CAPTURE -> no restart, wr_addr sequence unbroken.
REQ-039 Two full frames, no frame_ack -> overflow=1 after second FRAME_DONE, bank=0; frame_ack asserted same cycle as FRAME_DONE in separate run -> overflow=0, frame_ready=1.
REQ-040 enable dropped after 1st A-line in WAIT_TRIG -> IDLE, aline_count=0, bank unchanged, busy=0.
REQ-041 aclr pulsed after 3 samples -> all outputs at reset values immediately; sample_valid without trigger produces no wr_en.
REQ-042 With SWEEP_WATCHDOG_EN, WDOG_CYCLES=16: trigger, 3 samples, 16 idle cycles -> timeout=1, state WAIT_TRIG, aline_count=0; next trigger restarts wr_addr at 0.
